// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: reads rn/rm, holds operands on the external ALU,
// then conditionally writes rd back and updates the architectural NZCV flags.
//
// state | meaning
// IDLE  | waiting for an instruction, instr_ready high
// RD    | register file addresses for rn/rm presented
// EX    | operands held on the ALU; mul stays here MUL_CYCLES cycles
// WB    | condition check, write-back, flag update, retire pulse
module alu_exec_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  output logic        o_instr_ready,
  output logic [3:0]  o_rf_ra1,
  output logic [3:0]  o_rf_ra2,
  input  logic [31:0] i_rf_rd1,
  input  logic [31:0] i_rf_rd2,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [31:0] o_alu_inf,
  input  logic [31:0] i_alu_r,
  input  logic        i_alu_n,
  input  logic        i_alu_z,
  input  logic        i_alu_c,
  input  logic        i_alu_v,
  output logic        o_rf_we,
  output logic [3:0]  o_rf_wa,
  output logic [31:0] o_rf_wd,
  output logic [3:0]  o_flags,
  output logic        o_done,
  output logic        o_illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [3:0] OP_MUL   = 4'h2;
  localparam logic [3:0] OP_CMP   = 4'h8;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [31:0] r_alu_inf;
  logic [31:0] r_res;
  logic [3:0]  r_ra1;
  logic [3:0]  r_ra2;
  logic [3:0]  r_wa;
  logic [3:0]  r_cnt;
  logic [3:0]  r_hflags;
  logic [3:0]  r_flags;

  logic [3:0]  w_cond;
  logic [3:0]  w_op;
  logic        w_s;
  logic [3:0]  w_rd;
  logic        w_fn, w_fz, w_fc, w_fv;
  logic        w_pass;
  logic        w_writes;
  logic        w_sets_flags;
  logic        w_ex_last;
  logic        w_ready;
  logic        w_done;
  logic        w_we;
  logic        w_ill;
  logic        w_flag_upd;

  assign w_cond       = r_instr[31:28];
  assign w_op         = r_instr[27:24];
  assign w_s          = r_instr[23];
  assign w_rd         = r_instr[22:19];
  assign {w_fn, w_fz, w_fc, w_fv} = r_flags;
  assign w_writes     = (w_op <= 4'h7);
  assign w_sets_flags = (w_op == OP_CMP) | (w_s & w_writes);
  assign w_ex_last    = (r_cnt == 4'd0);

  // Condition is judged against the flags as they stood before this instruction.
  always_comb begin
    w_pass = 1'b0;
    case (w_cond)
      4'h0: w_pass = w_fz;
      4'h1: w_pass = ~w_fz;
      4'h2: w_pass = w_fc;
      4'h3: w_pass = ~w_fc;
      4'h4: w_pass = w_fn;
      4'h5: w_pass = ~w_fn;
      4'h6: w_pass = w_fv;
      4'h7: w_pass = ~w_fv;
      4'h8: w_pass = w_fc & ~w_fz;
      4'h9: w_pass = ~w_fc | w_fz;
      4'hA: w_pass = (w_fn == w_fv);
      4'hB: w_pass = (w_fn != w_fv);
      4'hC: w_pass = ~w_fz & (w_fn == w_fv);
      4'hD: w_pass = w_fz | (w_fn != w_fv);
      4'hE: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Retire outputs are gated by reset so an in-flight WB is dropped cleanly.
  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_done     = 1'b0;
    w_we       = 1'b0;
    w_ill      = 1'b0;
    w_flag_upd = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (i_instr_valid) w_next = S_RD;
      end
      S_RD: w_next = S_EX;
      S_EX: if (w_ex_last) w_next = S_WB;
      S_WB: begin
        w_next = S_IDLE;
        if (!i_rst) begin
          w_done     = 1'b1;
          w_ill      = (w_op > OP_CMP);
          w_we       = w_pass & w_writes;
          w_flag_upd = w_pass & w_sets_flags;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Addresses register on accept so the register file sees them for all of RD;
  // read data is sampled at the end of RD and held on the ALU through EX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr   <= '0;
      r_ra1     <= '0;
      r_ra2     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_inf <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_hflags  <= '0;
      r_wa      <= '0;
      r_flags   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_instr_valid) begin
            r_instr <= i_instr;
            r_ra1   <= i_instr[18:15];
            r_ra2   <= i_instr[14:11];
          end
        end
        S_RD: begin
          r_alu_a   <= i_rf_rd1;
          r_alu_b   <= i_rf_rd2;
          r_alu_inf <= {4'hE, r_instr[27:0]};
          r_cnt     <= (w_op == OP_MUL) ? MUL_LAST : 4'd0;
        end
        S_EX: begin
          if (w_ex_last) begin
            r_res    <= i_alu_r;
            r_hflags <= {i_alu_n, i_alu_z, i_alu_c, i_alu_v};
            r_wa     <= w_rd;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WB: if (w_flag_upd) r_flags <= r_hflags;
        default: ;
      endcase
    end
  end

  assign o_instr_ready = w_ready;
  assign o_rf_ra1      = r_ra1;
  assign o_rf_ra2      = r_ra2;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_inf     = r_alu_inf;
  assign o_rf_we       = w_we;
  assign o_rf_wa       = r_wa;
  assign o_rf_wd       = r_res;
  assign o_flags       = r_flags;
  assign o_done        = w_done;
  assign o_illegal     = w_ill;

endmodule
